// File: rtl/div.sv
// Sequential signed 32-bit divider: 32-iteration restoring division on magnitudes with MIPS DIV sign fix-up.
// Optional DIV_ZERO_TRAP_EN: a zero divisor aborts after one cycle with a div_zero pulse instead of running.
module div (
    input  logic        clk,
    input  logic        reset,
    input  logic        DivCtrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] high,
    output logic [31:0] low,
    output logic        div_end,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [31:0] rem_r;
    logic [31:0] dvd_r;
    logic [31:0] dsr_r;
    logic [5:0]  cnt_r;
    logic        sq_r;
    logic        sr_r;
    logic        bzero_r;

    logic [31:0] high_r;
    logic [31:0] low_r;
    logic        div_end_r;
    logic [31:0] high_nxt_s;
    logic [31:0] low_nxt_s;
    logic        div_end_nxt_s;

    logic [32:0] rem_sh_s;
    logic [31:0] diff_s;
    logic        trial_ok_s;
    logic [31:0] rem_nxt_s;
    logic [31:0] dvd_nxt_s;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // 0x80000000 maps to itself, which is exactly 2^31 read as unsigned
    function automatic logic [31:0] mag32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

    // One restoring step: the shifted remainder is 33 bits wide, so the trial subtract
    // is decided by a full-width compare and the 32-bit difference is exact when it succeeds.
    always_comb begin
        rem_sh_s   = {rem_r, dvd_r[31]};
        trial_ok_s = (rem_sh_s >= {1'b0, dsr_r});
        diff_s     = rem_sh_s[31:0] - dsr_r;
        if (trial_ok_s) begin
            rem_nxt_s = diff_s;
        end else begin
            rem_nxt_s = rem_sh_s[31:0];
        end
        dvd_nxt_s  = {dvd_r[30:0], trial_ok_s};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (DivCtrl) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
`ifdef DIV_ZERO_TRAP_EN
                if (bzero_r) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == 6'd1) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
`else
                if (cnt_r == 6'd1) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
`endif
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        high_nxt_s    = high_r;
        low_nxt_s     = low_r;
        div_end_nxt_s = 1'b0;
        case (state_r)
            DONE: begin
                if (bzero_r) begin
                    low_nxt_s = 32'hFFFF_FFFF;
                end else if (sq_r) begin
                    low_nxt_s = neg32(dvd_r);
                end else begin
                    low_nxt_s = dvd_r;
                end
                // With a zero divisor the remainder equals |a|, so this reproduces a.
                if (sr_r) begin
                    high_nxt_s = neg32(rem_r);
                end else begin
                    high_nxt_s = rem_r;
                end
                div_end_nxt_s = 1'b1;
            end
            default: begin
                high_nxt_s    = high_r;
                low_nxt_s     = low_r;
                div_end_nxt_s = 1'b0;
            end
        endcase
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_r   <= 32'd0;
            dvd_r   <= 32'd0;
            dsr_r   <= 32'd0;
            cnt_r   <= 6'd0;
            sq_r    <= 1'b0;
            sr_r    <= 1'b0;
            bzero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (DivCtrl) begin
                        rem_r   <= 32'd0;
                        dvd_r   <= mag32(a);
                        dsr_r   <= mag32(b);
                        cnt_r   <= 6'd32;
                        sq_r    <= a[31] ^ b[31];
                        sr_r    <= a[31];
                        bzero_r <= (b == 32'd0);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                RUN: begin
                    rem_r <= rem_nxt_s;
                    dvd_r <= dvd_nxt_s;
                    cnt_r <= cnt_r - 6'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result and completion registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_r    <= 32'd0;
            low_r     <= 32'd0;
            div_end_r <= 1'b0;
        end else begin
            high_r    <= high_nxt_s;
            low_r     <= low_nxt_s;
            div_end_r <= div_end_nxt_s;
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    logic div_zero_r;

    // Divide-by-zero pulse, raised on the single RUN cycle of a trapped operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_zero_r <= 1'b0;
        end else if (state_r == RUN) begin
            div_zero_r <= bzero_r;
        end else begin
            div_zero_r <= 1'b0;
        end
    end

    assign div_zero = div_zero_r;
`else
    assign div_zero = 1'b0;
`endif

    assign high    = high_r;
    assign low     = low_r;
    assign div_end = div_end_r;

endmodule
